sign_narrow16_4: RTL and testbench

- Inverse of the immediate sign extender: narrows a 16-bit signed word to a 4-bit signed field.
- Flags words that are not representable in 4 bits and optionally saturates them.
- Sits between the ALU/register-file result path and instruction/immediate encoding logic.
- Valid/ready streaming block with a 2-entry output buffer and a saturating overflow counter.

---
 rtl/sign_narrow16_4.sv | 122 ++++++++++++
 tb/tb_sign_narrow16_4.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_narrow16_4.sv
// Narrows a signed IN_W-bit word to a signed OUT_W-bit field, flagging (and optionally
// saturating) unrepresentable words, behind a 2-entry valid/ready output buffer.
module sign_narrow16_4 #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 4,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [OUT_W-1:0] value;
        logic             ovf;
    } entry_t;

    occ_e             state_q;
    entry_t           head_q;
    entry_t           tail_q;
    entry_t           new_entry;
    logic [CNT_W-1:0] ovf_count_q;
    logic [CNT_W-1:0] ovf_count_d;
    logic [IN_W-OUT_W:0] upper;
    logic             fits;
    logic             push;
    logic             pop;

    // A word fits when every bit from the top down to the field's sign bit agrees.
    assign upper = in_data[IN_W-1:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        new_entry.value = in_data[OUT_W-1:0];
        new_entry.ovf   = ~fits;
        if (!fits && (SATURATE != 0)) begin
            new_entry.value = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                              : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Handshake flags decode registered occupancy only; out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= new_entry;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q  <= new_entry;
                        state_q <= FULL;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Head is never cleared on pop, so out_data/out_ovf hold their last value when empty.
    assign out_data = head_q.value;
    assign out_ovf  = head_q.ovf;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_count) begin
            ovf_count_d = '0;
        end else if (push && !fits && (ovf_count_q != {CNT_W{1'b1}})) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_sign_narrow16_4.sv
// Scoreboard bench for sign_narrow16_4: a saturating and a truncating instance share one
// stimulus stream; expected entries are queued on accept and compared on pop.
module tb_sign_narrow16_4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [3:0]  out_data_s;
    logic [7:0]  ovf_count_s;
    logic        in_ready_t, out_valid_t, out_ovf_t;
    logic [3:0]  out_data_t;
    logic [7:0]  ovf_count_t;

    typedef struct packed {
        logic [3:0] sat;
        logic [3:0] trunc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_model = 0;
    bit   acc;

    always #5 clk = ~clk;

    sign_narrow16_4 #(.IN_W(16), .OUT_W(4), .SATURATE(1), .CNT_W(8)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ovf(out_ovf_s),
        .ovf_count(ovf_count_s), .clr_count(clr_count)
    );

    sign_narrow16_4 #(.IN_W(16), .OUT_W(4), .SATURATE(0), .CNT_W(8)) dut_trunc (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .out_data(out_data_t), .out_ovf(out_ovf_t),
        .ovf_count(ovf_count_t), .clr_count(clr_count)
    );

    // Reference narrowing from the integer value of the word.
    function automatic exp_t model(input logic [15:0] d);
        int   v;
        exp_t e;
        v       = int'($signed(d));
        e.trunc = d[3:0];
        e.ovf   = (v > 7) || (v < -8);
        e.sat   = (v > 7) ? 4'h7 : ((v < -8) ? 4'h8 : d[3:0]);
        return e;
    endfunction

    // One clock: pop/compare and push at the negedge, then check counters after the edge.
    task automatic step();
        exp_t e;
        exp_t n;
        @(negedge clk);
        acc = 1'b0;
        n   = model(in_data);
        if (out_valid_s && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_empty: got out_data=%h, expected no output", out_data_s);
            end else begin
                e = sb.pop_front();
                if ({out_data_s, out_ovf_s} !== {e.sat, e.ovf}) begin
                    errors++;
                    $display("FAIL sat_out: got data=%h ovf=%b, expected data=%h ovf=%b",
                             out_data_s, out_ovf_s, e.sat, e.ovf);
                end
                checks++;
                if ({out_data_t, out_ovf_t} !== {e.trunc, e.ovf}) begin
                    errors++;
                    $display("FAIL trunc_out: got data=%h ovf=%b, expected data=%h ovf=%b",
                             out_data_t, out_ovf_t, e.trunc, e.ovf);
                end
            end
        end
        if (in_valid && in_ready_s) begin
            acc = 1'b1;
            sb.push_back(n);
        end
        if (clr_count) cnt_model = 0;
        else if (acc && n.ovf && cnt_model < 255) cnt_model++;
        @(posedge clk);
        #1;
        checks++;
        if (ovf_count_s !== 8'(cnt_model) || ovf_count_t !== 8'(cnt_model)) begin
            errors++;
            $display("FAIL ovf_count: got %0d/%0d, expected %0d", ovf_count_s, ovf_count_t, cnt_model);
        end
        checks++;
        if (out_valid_s !== (sb.size() != 0) || out_valid_t !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b/%b, expected %b", out_valid_s, out_valid_t, sb.size() != 0);
        end
    endtask

    task automatic send(input logic [15:0] w);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            step();
            budget++;
        end while (!acc && budget < 50);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: word %h got accepted=0, expected accepted=1", w);
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        checks++;
        if (sb.size() != 0 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL drain: got %0d pending, out_valid=%b, expected 0 pending", sb.size(), out_valid_s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        #1;
        checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || out_data_s !== 4'h0 ||
            out_ovf_s !== 1'b0 || ovf_count_s !== 8'h00 || out_data_t !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%h ovf=%b cnt=%0d, expected 0 1 0 0 0",
                     out_valid_s, in_ready_s, out_data_s, out_ovf_s, ovf_count_s);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_in_range();
        out_ready = 1'b1;
        send(16'h0007);
        checks++;
        if (out_valid_s !== 1'b1 || out_data_s !== 4'h7) begin
            errors++;
            $display("FAIL latency: got valid=%b data=%h, expected valid=1 data=7", out_valid_s, out_data_s);
        end
        send(16'hFFF8);
        send(16'h0000);
        send(16'hFFFF);
        drain();
        checks++;
        if (ovf_count_s !== 8'd0 || out_data_s !== 4'hF || out_ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL in_range_end: got cnt=%0d data=%h ovf=%b, expected cnt=0 data=f ovf=0",
                     ovf_count_s, out_data_s, out_ovf_s);
        end
    endtask

    task automatic test_saturation();
        send(16'h0008);
        checks++;
        if (out_data_s !== 4'h7 || out_ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got data=%h ovf=%b, expected data=7 ovf=1", out_data_s, out_ovf_s);
        end
        send(16'h8000);
        send(16'hFFF7);
        drain();
        checks++;
        if (ovf_count_s !== 8'd3 || out_data_s !== 4'h8) begin
            errors++;
            $display("FAIL sat_end: got cnt=%0d data=%h, expected cnt=3 data=8", ovf_count_s, out_data_s);
        end
    endtask

    task automatic test_truncation();
        send(16'h0008);
        checks++;
        if (out_data_t !== 4'h8 || out_ovf_t !== 1'b1) begin
            errors++;
            $display("FAIL trunc_0008: got data=%h ovf=%b, expected data=8 ovf=1", out_data_t, out_ovf_t);
        end
        send(16'h1234);
        checks++;
        if (out_data_t !== 4'h4 || out_ovf_t !== 1'b1 || out_data_s !== 4'h7) begin
            errors++;
            $display("FAIL trunc_1234: got trunc=%h ovf=%b sat=%h, expected trunc=4 ovf=1 sat=7",
                     out_data_t, out_ovf_t, out_data_s);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h0001);
        send(16'h0002);
        in_valid = 1'b1;
        in_data  = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (acc || in_ready_s !== 1'b0 || out_data_s !== 4'h1) begin
                errors++;
                $display("FAIL stall: got accepted=%b in_ready=%b data=%h, expected 0 0 1",
                         acc, in_ready_s, out_data_s);
            end
        end
        out_ready = 1'b1;
        send(16'h0003);
        checks++;
        if (out_valid_s !== 1'b1 || out_data_s !== 4'h3) begin
            errors++;
            $display("FAIL push_pop_one: got valid=%b data=%h, expected valid=1 data=3", out_valid_s, out_data_s);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(16'h0008);
        send(16'h8000);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || ovf_count_s !== 8'd0 ||
            out_data_s !== 4'h0 || out_ovf_s !== 1'b0 || out_valid_t !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b ready=%b cnt=%0d data=%h ovf=%b, expected 0 1 0 0 0",
                     out_valid_s, in_ready_s, ovf_count_s, out_data_s, out_ovf_s);
        end
        sb.delete();
        cnt_model = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic test_counter();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 16'h4000 : 16'hC000);
        checks++;
        if (ovf_count_s !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat: got %0d, expected 255", ovf_count_s);
        end
        clr_count = 1'b1;
        send(16'h0100);
        clr_count = 1'b0;
        checks++;
        if (ovf_count_s !== 8'd0) begin
            errors++;
            $display("FAIL cnt_clear: got %0d, expected 0", ovf_count_s);
        end
        send(16'h8000);
        checks++;
        if (ovf_count_s !== 8'd1) begin
            errors++;
            $display("FAIL cnt_after_clear: got %0d, expected 1", ovf_count_s);
        end
        drain();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_in_range();
        test_saturation();
        test_truncation();
        test_backpressure();
        test_reset_midstream();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
